// File: rtl/tpg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpg_pkg
// Description : Shared definitions for the multi-pattern test pattern
//               generator: pattern mode codes, FSM states and bar colours.
// Revision    : 1.0 - initial release
// ============================================================================
package tpg_pkg;

   // Pattern select codes; codes 5..7 fall through to solid colour
   localparam logic [2:0] MODE_COUNT   = 3'd0;
   localparam logic [2:0] MODE_RAMP    = 3'd1;
   localparam logic [2:0] MODE_BARS    = 3'd2;
   localparam logic [2:0] MODE_CHECKER = 3'd3;
   localparam logic [2:0] MODE_SOLID   = 3'd4;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Colour bar table as an {R,G,B} on/off mask:
   // white, yellow, cyan, green, magenta, red, blue, black
   function automatic logic [2:0] bar_color(input logic [2:0] idx);
      logic [2:0] c;
      case (idx)
         3'd0:    c = 3'b111;
         3'd1:    c = 3'b110;
         3'd2:    c = 3'b011;
         3'd3:    c = 3'b010;
         3'd4:    c = 3'b101;
         3'd5:    c = 3'b100;
         3'd6:    c = 3'b001;
         default: c = 3'b000;
      endcase
      return c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tpg_pattern.sv
`default_nettype none
// ============================================================================
// Module      : tpg_pattern
// Description : Combinational pixel colour generator. Maps the latched mode,
//               active-area coordinates and running pixel count to {R,G,B}.
//               Blanking outside the active area is applied by the caller.
// Revision    : 1.0 - initial release
// ============================================================================
module tpg_pattern
   import tpg_pkg::*;
#(
   parameter int PW       = 8,
   parameter int H_BITS   = 12,
   parameter int V_BITS   = 12,
   parameter int BAR_LOG2 = 6,
   parameter int CHK_LOG2 = 4
) (
   input  logic [2:0]        mode_i,
   input  logic [H_BITS-1:0] xa_i,
   input  logic [V_BITS-1:0] ya_i,
   input  logic [PW-1:0]     cnt_i,
   input  logic [3*PW-1:0]   solid_rgb_i,
   output logic [3*PW-1:0]   rgb_o
);

   logic [H_BITS-1:0] bar_pos;
   logic [2:0]        bar_idx;
   logic [2:0]        bar_mask;
   logic [H_BITS-1:0] chk_xor;
   logic              chk_on;

   // Select the colour of the current pixel for the active pattern
   always_comb begin
      bar_pos  = xa_i >> BAR_LOG2;
      // Everything right of the eighth bar is clamped to the last (black) bar
      bar_idx  = (bar_pos > H_BITS'(7)) ? 3'd7 : bar_pos[2:0];
      bar_mask = bar_color(bar_idx);
      chk_xor  = (xa_i >> CHK_LOG2) ^ H_BITS'(ya_i >> CHK_LOG2);
      chk_on   = chk_xor[0];
      case (mode_i)
         MODE_COUNT:   rgb_o = {3{cnt_i}};
         MODE_RAMP:    rgb_o = {3{xa_i[PW-1:0]}};
         MODE_BARS:    rgb_o = {{PW{bar_mask[2]}}, {PW{bar_mask[1]}}, {PW{bar_mask[0]}}};
         MODE_CHECKER: rgb_o = {(3*PW){chk_on}};
         default:      rgb_o = solid_rgb_i;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/tpg_multi.sv
`default_nettype none
// ============================================================================
// Module      : tpg_multi
// Description : Multi-pattern video test pattern generator. Produces H/V sync,
//               data enable, start-of-frame / end-of-line markers, a frame
//               counter and an RGB pixel stream from five selectable patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module tpg_multi
   import tpg_pkg::*;
#(
   parameter int PW       = 8,
   parameter int H_BITS   = 12,
   parameter int V_BITS   = 12,
   parameter int BAR_LOG2 = 6,
   parameter int CHK_LOG2 = 4,
   parameter int FC_BITS  = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [2:0]         mode,
   input  logic [3*PW-1:0]    solid_rgb,
   input  logic [H_BITS-1:0]  tHS_START,
   input  logic [H_BITS-1:0]  tHS_END,
   input  logic [H_BITS-1:0]  tHACT_START,
   input  logic [H_BITS-1:0]  tHACT_END,
   input  logic [H_BITS-1:0]  tH_END,
   input  logic [V_BITS-1:0]  tVS_START,
   input  logic [V_BITS-1:0]  tVS_END,
   input  logic [V_BITS-1:0]  tVACT_START,
   input  logic [V_BITS-1:0]  tVACT_END,
   input  logic [V_BITS-1:0]  tV_END,
   output logic               hs,
   output logic               vs,
   output logic               de,
   output logic               sof,
   output logic               eol,
   output logic [3*PW-1:0]    rgb,
   output logic [FC_BITS-1:0] frame_cnt
);

   localparam logic [H_BITS-1:0]  H_ONE  = H_BITS'(1);
   localparam logic [V_BITS-1:0]  V_ONE  = V_BITS'(1);
   localparam logic [PW-1:0]      P_ONE  = PW'(1);
   localparam logic [FC_BITS-1:0] FC_ONE = FC_BITS'(1);

   state_t              state_q, state_d;
   logic [H_BITS-1:0]   x_q, x_d;
   logic [V_BITS-1:0]   y_q, y_d;
   logic [2:0]          mode_q;
   logic [PW-1:0]       cnt_q;
   logic                hs_q, vs_q, de_q, sof_q, eol_q;
   logic [3*PW-1:0]     rgb_q;
   logic [FC_BITS-1:0]  frame_cnt_q;

   logic                last_x, last_y, at_origin;
   logic                hs_w, vs_w, de_w;
   logic [H_BITS-1:0]   xa;
   logic [V_BITS-1:0]   ya;
   logic [2:0]          mode_eff;
   logic [PW-1:0]       cnt_pix;
   logic [3*PW-1:0]     pat_rgb;

   // Decode timing windows and pattern inputs for the current counter position
   always_comb begin
      last_x    = (x_q == tH_END - H_ONE);
      last_y    = (y_q == tV_END - V_ONE);
      at_origin = (x_q == '0) && (y_q == '0);
      hs_w      = (x_q >= tHS_START) && (x_q < tHS_END);
      vs_w      = (y_q >= tVS_START) && (y_q < tVS_END);
      de_w      = (x_q >= tHACT_START) && (x_q < tHACT_END) &&
                  (y_q >= tVACT_START) && (y_q < tVACT_END);
      xa        = x_q - tHACT_START;
      ya        = y_q - tVACT_START;
      // The first pixel of a frame already uses the newly sampled mode and a
      // freshly cleared count, so the frame is self-consistent from sof on
      mode_eff  = at_origin ? mode : mode_q;
      cnt_pix   = (at_origin ? '0 : cnt_q) + P_ONE;
   end

   tpg_pattern #(
      .PW       (PW),
      .H_BITS   (H_BITS),
      .V_BITS   (V_BITS),
      .BAR_LOG2 (BAR_LOG2),
      .CHK_LOG2 (CHK_LOG2)
   ) u_pattern (
      .mode_i      (mode_eff),
      .xa_i        (xa),
      .ya_i        (ya),
      .cnt_i       (cnt_pix),
      .solid_rgb_i (solid_rgb),
      .rgb_o       (pat_rgb)
   );

   // Next state and raster position; en is only honoured at frame boundaries
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         ST_IDLE: begin
            x_d = '0;
            y_d = '0;
            if (en) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (last_x) begin
               x_d = '0;
               if (last_y) begin
                  y_d = '0;
                  if (!en) state_d = ST_IDLE;
               end else begin
                  y_d = y_q + V_ONE;
               end
            end else begin
               x_d = x_q + H_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and raster counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // Output registers, pattern state and frame counter
   always_ff @(posedge clk) begin
      if (rst) begin
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         de_q        <= 1'b0;
         sof_q       <= 1'b0;
         eol_q       <= 1'b0;
         rgb_q       <= '0;
         mode_q      <= MODE_COUNT;
         cnt_q       <= '0;
         frame_cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
         hs_q  <= hs_w;
         vs_q  <= vs_w;
         de_q  <= de_w;
         sof_q <= at_origin;
         eol_q <= last_x;
         rgb_q <= de_w ? pat_rgb : '0;
         if (at_origin) mode_q <= mode;
         if (de_w) begin
            cnt_q <= cnt_pix;
         end else if (at_origin) begin
            cnt_q <= '0;
         end
         if (last_x && last_y) frame_cnt_q <= frame_cnt_q + FC_ONE;
      end else begin
         hs_q  <= 1'b0;
         vs_q  <= 1'b0;
         de_q  <= 1'b0;
         sof_q <= 1'b0;
         eol_q <= 1'b0;
         rgb_q <= '0;
      end
   end

   assign hs        = hs_q;
   assign vs        = vs_q;
   assign de        = de_q;
   assign sof       = sof_q;
   assign eol       = eol_q;
   assign rgb       = rgb_q;
   assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tpg_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpg_multi
// Description : Directed self-checking bench for tpg_multi.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpg_multi;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [2:0]  mode;
   logic [23:0] solid_rgb;
   logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
   logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
   logic        hs, vs, de, sof, eol;
   logic [23:0] rgb;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   tpg_multi #(
      .PW(8), .H_BITS(12), .V_BITS(12), .BAR_LOG2(1), .CHK_LOG2(1), .FC_BITS(16)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid_rgb),
      .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
      .tHACT_END(tHACT_END), .tH_END(tH_END),
      .tVS_START(tVS_START), .tVS_END(tVS_END), .tVACT_START(tVACT_START),
      .tVACT_END(tVACT_END), .tV_END(tV_END),
      .hs(hs), .vs(vs), .de(de), .sof(sof), .eol(eol), .rgb(rgb), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic set_timing_a();
      tH_END = 12'd16; tHS_START = 12'd1; tHS_END = 12'd3; tHACT_START = 12'd4; tHACT_END = 12'd12;
      tV_END = 12'd6;  tVS_START = 12'd0; tVS_END = 12'd1; tVACT_START = 12'd2; tVACT_END = 12'd5;
   endtask

   task automatic set_timing_b();
      tH_END = 12'd24; tHS_START = 12'd0; tHS_END = 12'd2; tHACT_START = 12'd2; tHACT_END = 12'd22;
      tV_END = 12'd4;  tVS_START = 12'd0; tVS_END = 12'd1; tVACT_START = 12'd0; tVACT_END = 12'd4;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; mode = 3'd0; solid_rgb = 24'h0;
      set_timing_a();
      repeat (2) @(negedge clk);
      n_checks++;
      if ({hs, vs, de, sof, eol, rgb, frame_cnt} !== 45'h0)
         $display("FAIL reset_outputs: got %h expected 0", {hs, vs, de, sof, eol, rgb, frame_cnt});
      else n_pass++;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({hs, vs, de, sof, eol, rgb, frame_cnt} !== 45'h0)
         $display("FAIL idle_outputs: got %h expected 0", {hs, vs, de, sof, eol, rgb, frame_cnt});
      else n_pass++;
   endtask

   task automatic test_count();
      logic [7:0]  c;
      logic [15:0] efc;
      logic [44:0] exp_v, got_v;
      logic        ede;
      int x, y;
      en = 1'b1; mode = 3'd0;
      @(negedge clk);
      n_checks++;
      if (sof !== 1'b0) $display("FAIL sof_latency_1: got %b expected 0", sof); else n_pass++;
      @(negedge clk);
      n_checks++;
      if (sof !== 1'b1) $display("FAIL sof_latency_2: got %b expected 1", sof); else n_pass++;
      c = 8'd0; efc = 16'd0;
      for (int k = 0; k < 192; k++) begin
         x = k % 16; y = (k % 96) / 16;
         if (x == 0 && y == 0) c = 8'd0;
         ede = (x >= 4) && (x < 12) && (y >= 2) && (y < 5);
         if (ede) c = c + 8'd1;
         if (k % 96 == 95) efc = efc + 16'd1;
         exp_v = {(x >= 1 && x < 3), (y < 1), ede, (k % 96 == 0), (x == 15),
                  ede ? {c, c, c} : 24'h0, efc};
         got_v = {hs, vs, de, sof, eol, rgb, frame_cnt};
         n_checks++;
         if (got_v !== exp_v) $display("FAIL count_frame k=%0d: got %h expected %h", k, got_v, exp_v);
         else n_pass++;
         if (k == 75) begin
            n_checks++;
            if (rgb !== 24'h181818) $display("FAIL count_last_pixel: got %h expected 181818", rgb);
            else n_pass++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_en_drop();
      int n;
      n_checks++;
      if (sof !== 1'b1) $display("FAIL frame3_sof: got %b expected 1", sof); else n_pass++;
      repeat (40) @(negedge clk);
      en = 1'b0;
      n = 0;
      while (n < 200 && frame_cnt === 16'd2) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n != 55) $display("FAIL frame3_completion_cycles: got %0d expected 55", n); else n_pass++;
      n_checks++;
      if ({eol, frame_cnt} !== {1'b1, 16'd3})
         $display("FAIL frame3_end: got eol=%b fc=%0d expected eol=1 fc=3", eol, frame_cnt);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_checks++;
         if ({hs, vs, de, sof, eol, rgb, frame_cnt} !== {29'h0, 16'd3})
            $display("FAIL idle_after_drop i=%0d: got %h expected %h", i,
                     {hs, vs, de, sof, eol, rgb, frame_cnt}, {29'h0, 16'd3});
         else n_pass++;
      end
      en = 1'b1;
      @(negedge clk);
      n_checks++;
      if (sof !== 1'b0) $display("FAIL restart_sof_1: got %b expected 0", sof); else n_pass++;
      @(negedge clk);
      n_checks++;
      if (sof !== 1'b1) $display("FAIL restart_sof_2: got %b expected 1", sof); else n_pass++;
   endtask

   task automatic test_reset_mid();
      int n;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({hs, vs, de, sof, eol, rgb, frame_cnt} !== 45'h0)
         $display("FAIL reset_mid_outputs: got %h expected 0", {hs, vs, de, sof, eol, rgb, frame_cnt});
      else n_pass++;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (sof !== 1'b0) $display("FAIL reset_restart_sof_1: got %b expected 0", sof); else n_pass++;
      @(negedge clk);
      n_checks++;
      if (sof !== 1'b1) $display("FAIL reset_restart_sof_2: got %b expected 1", sof); else n_pass++;
      repeat (36) @(negedge clk);
      n_checks++;
      if ({de, rgb} !== {1'b1, 24'h010101})
         $display("FAIL reset_first_pixel: got de=%b rgb=%h expected de=1 rgb=010101", de, rgb);
      else n_pass++;
      repeat (59) @(negedge clk);
      n_checks++;
      if ({eol, frame_cnt} !== {1'b1, 16'd1})
         $display("FAIL reset_frame_end: got eol=%b fc=%0d expected eol=1 fc=1", eol, frame_cnt);
      else n_pass++;
      en = 1'b0;
      n = 0;
      while (n < 200 && frame_cnt === 16'd1) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (frame_cnt !== 16'd2) $display("FAIL drain_to_idle: got fc=%0d expected 2", frame_cnt); else n_pass++;
   endtask

   task automatic test_bars();
      logic [23:0] tbl [8];
      logic [23:0] e;
      int n, x, xa;
      tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
      set_timing_b();
      mode = 3'd2; en = 1'b1;
      n = 0;
      while (n < 10 && sof !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (sof !== 1'b1) $display("FAIL bars_sof_timeout: got sof=%b expected 1", sof); else n_pass++;
      for (int k = 0; k < 48; k++) begin
         x = k % 24; xa = x - 2;
         e = 24'h0;
         if (x >= 2 && x < 22 && xa < 16) e = tbl[xa / 2];
         n_checks++;
         if (rgb !== e) $display("FAIL bars k=%0d: got %h expected %h", k, rgb, e); else n_pass++;
         if (k == 23) mode = 3'd3;
         @(negedge clk);
      end
   endtask

   task automatic test_checker();
      logic [23:0] e;
      int n, x, y, xa;
      n = 0;
      while (n < 100 && sof !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (sof !== 1'b1) $display("FAIL checker_sof_timeout: got sof=%b expected 1", sof); else n_pass++;
      for (int k = 0; k < 96; k++) begin
         x = k % 24; y = k / 24; xa = x - 2;
         e = 24'h0;
         if (x >= 2 && x < 22 && (((xa >> 1) ^ (y >> 1)) & 1) == 1) e = 24'hFFFFFF;
         n_checks++;
         if (rgb !== e) $display("FAIL checker k=%0d: got %h expected %h", k, rgb, e); else n_pass++;
         if (k == 2) begin
            n_checks++;
            if ({de, rgb} !== {1'b1, 24'h0})
               $display("FAIL checker_origin: got de=%b rgb=%h expected de=1 rgb=000000", de, rgb);
            else n_pass++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_mode_change();
      logic [23:0] e;
      logic [7:0]  xa8;
      int n, x;
      mode = 3'd1; solid_rgb = 24'h123456;
      @(negedge clk);
      n = 0;
      while (n < 200 && sof !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (sof !== 1'b1) $display("FAIL ramp_sof_timeout: got sof=%b expected 1", sof); else n_pass++;
      for (int k = 0; k < 96; k++) begin
         x = k % 24; xa8 = 8'(x - 2);
         e = (x >= 2 && x < 22) ? {xa8, xa8, xa8} : 24'h0;
         n_checks++;
         if (rgb !== e) $display("FAIL ramp k=%0d: got %h expected %h", k, rgb, e); else n_pass++;
         if (k == 40) begin
            n_checks++;
            if (rgb !== 24'h0E0E0E) $display("FAIL ramp_after_change: got %h expected 0e0e0e", rgb);
            else n_pass++;
         end
         if (k == 29) mode = 3'd4;
         @(negedge clk);
      end
      n_checks++;
      if (sof !== 1'b1) $display("FAIL solid_sof: got sof=%b expected 1", sof); else n_pass++;
      for (int k = 0; k < 96; k++) begin
         x = k % 24;
         e = (x >= 2 && x < 22) ? 24'h123456 : 24'h0;
         n_checks++;
         if (rgb !== e) $display("FAIL solid k=%0d: got %h expected %h", k, rgb, e); else n_pass++;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_en_drop();
      test_reset_mid();
      test_bars();
      test_checker();
      test_mode_change();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
